phrase_sequencer: RTL and testbench

Phrase store and playhead that feeds the per-channel phrase playback block. Holds one 16-line phrase, accepts entry writes from the editor over a valid/ready port, and derives line steps from a tempo accumulator. Presents the entry under the playhead as `current_entry`. One instance per channel; its outputs drive the playback block's `current_entry` input.

---
 rtl/tracker_pkg.sv | 18 +
 rtl/tempo_tick_gen.sv | 44 ++++
 rtl/phrase_sequencer.sv | 150 +++++++++++++++
 tb/tb_phrase_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tracker_pkg.sv
// Types and constants shared by the tracker sequencer levels (phrase, chain, song).
package tracker_pkg;

    localparam int LINES       = 16;
    localparam int ENTRY_W     = 16;
    localparam int SEC_PER_MIN = 60;

    typedef logic [ENTRY_W-1:0] entry_t;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        PLAYING,
        PAUSED,
        DONE
    } seq_state_t;

endpackage

// File: rtl/tempo_tick_gen.sv
// Modulo tempo accumulator: adds lines-per-minute each run cycle and emits a step
// whenever the sum crosses CLK_FREQ*60, so step rate = tempo lines per minute.
module tempo_tick_gen #(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       clear,
    input  logic [8:0] tempo,
    output logic       step
);
    import tracker_pkg::*;

    localparam longint unsigned MOD   = 64'(CLK_FREQ) * 64'(SEC_PER_MIN);
    localparam int              A     = $clog2(MOD);
    localparam logic [A:0]      MOD_W = (A+1)'(MOD);

    logic [A-1:0] acc_q, acc_d;
    logic [A:0]   sum;

    // One extra bit on the sum so the compare against MOD cannot overflow.
    always_comb begin
        sum   = {1'b0, acc_q} + (A+1)'(tempo);
        acc_d = acc_q;
        step  = 1'b0;
        if (clear) begin
            acc_d = '0;
        end else if (run) begin
            if (sum >= MOD_W) begin
                acc_d = A'(sum - MOD_W);
                step  = 1'b1;
            end else begin
                acc_d = A'(sum);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

endmodule

// File: rtl/phrase_sequencer.sv
// One-channel phrase store plus playhead; presents the entry under the playhead
// to the playback block and steps lines at the programmed tempo.
module phrase_sequencer #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int LINES    = tracker_pkg::LINES,
    parameter int ENTRY_W  = $bits(tracker_pkg::entry_t)
) (
    input  logic                     clk,
    input  logic                     rst_active_high,
    input  logic [8:0]               tempo,
    input  logic                     play_enable,
    input  logic                     stop,
    input  logic                     loop_enable,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [$clog2(LINES)-1:0] wr_addr,
    input  logic [ENTRY_W-1:0]       wr_data,
    output logic [ENTRY_W-1:0]       current_entry,
    output logic [$clog2(LINES)-1:0] line_count,
    output logic                     line_strobe,
    output logic                     playing,
    output logic                     phrase_done
);
    import tracker_pkg::*;

    localparam int            LW   = $clog2(LINES);
    localparam logic [LW-1:0] LAST = LW'(LINES - 1);

    seq_state_t         state_q, state_d;
    logic [LW-1:0]      line_count_q, line_count_d;
    logic [LW-1:0]      clr_addr_q, clr_addr_d;
    logic [ENTRY_W-1:0] cur_entry_q, cur_entry_d;
    logic               line_strobe_q, line_strobe_d;
    logic               phrase_done_q, phrase_done_d;
    logic [ENTRY_W-1:0] mem_q [LINES];

    logic               mem_we;
    logic [LW-1:0]      mem_waddr;
    logic [ENTRY_W-1:0] mem_wdata;
    logic               wr_fire;
    logic               stop_hit;
    logic               step;
    logic               acc_run;
    logic               acc_clear;

    assign stop_hit  = stop && (state_q inside {PLAYING, PAUSED, DONE});
    assign acc_run   = (state_q == PLAYING);
    assign acc_clear = (state_q inside {CLEAR, IDLE}) || stop_hit;

    tempo_tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_tick (
        .clk   (clk),
        .rst   (rst_active_high),
        .run   (acc_run),
        .clear (acc_clear),
        .tempo (tempo),
        .step  (step)
    );

    always_comb begin
        state_d       = state_q;
        line_count_d  = line_count_q;
        clr_addr_d    = clr_addr_q;
        line_strobe_d = 1'b0;
        phrase_done_d = 1'b0;
        wr_fire       = wr_valid && (state_q != CLEAR);
        mem_we        = wr_fire;
        mem_waddr     = wr_addr;
        mem_wdata     = wr_data;

        if (stop_hit) begin
            state_d      = IDLE;
            line_count_d = '0;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    mem_we     = 1'b1;
                    mem_waddr  = clr_addr_q;
                    mem_wdata  = '0;
                    clr_addr_d = clr_addr_q + 1'b1;
                    if (clr_addr_q == LAST) state_d = IDLE;
                end
                IDLE: begin
                    line_count_d = '0;
                    if (play_enable) state_d = PLAYING;
                end
                PLAYING: begin
                    if (step) begin
                        // A non-looping phrase parks on its last line instead of wrapping.
                        if (line_count_q == LAST && !loop_enable) begin
                            state_d       = DONE;
                            phrase_done_d = 1'b1;
                        end else begin
                            line_count_d  = line_count_q + 1'b1;
                            line_strobe_d = 1'b1;
                        end
                    end
                    if (state_d == PLAYING && !play_enable) state_d = PAUSED;
                end
                PAUSED: begin
                    if (play_enable) state_d = PLAYING;
                end
                DONE: begin
                    if (!play_enable) begin
                        state_d      = IDLE;
                        line_count_d = '0;
                    end
                end
                default: state_d = CLEAR;
            endcase
        end

        // Read the line the playhead lands on, forwarding a same-edge write to it.
        if (state_q == CLEAR)                         cur_entry_d = '0;
        else if (wr_fire && wr_addr == line_count_d)  cur_entry_d = wr_data;
        else                                          cur_entry_d = mem_q[line_count_d];
    end

    always_ff @(posedge clk or posedge rst_active_high) begin
        if (rst_active_high) begin
            state_q       <= CLEAR;
            line_count_q  <= '0;
            clr_addr_q    <= '0;
            cur_entry_q   <= '0;
            line_strobe_q <= 1'b0;
            phrase_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            line_count_q  <= line_count_d;
            clr_addr_q    <= clr_addr_d;
            cur_entry_q   <= cur_entry_d;
            line_strobe_q <= line_strobe_d;
            phrase_done_q <= phrase_done_d;
        end
    end

    // Contents need no reset: CLEAR rewrites every line before the port opens.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign wr_ready      = (state_q != CLEAR);
    assign playing       = (state_q == PLAYING);
    assign current_entry = cur_entry_q;
    assign line_count    = line_count_q;
    assign line_strobe   = line_strobe_q;
    assign phrase_done   = phrase_done_q;

endmodule

// File: tb/tb_phrase_sequencer.sv
// Bench for phrase_sequencer: directed test-plan scenarios plus a random phase,
// every cycle compared against a behavioural model of the phrase player.
module tb_phrase_sequencer;

    localparam int CF = 60;
    localparam int M  = CF * 60;
    localparam int NL = 16;

    localparam int S_CLEAR = 0, S_IDLE = 1, S_PLAY = 2, S_PAUSE = 3, S_DONE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  tempo;
    logic        pe, stop, loop_en, wv;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        wr_ready, line_strobe, playing, phrase_done;
    logic [15:0] current_entry;
    logic [3:0]  line_count;

    phrase_sequencer #(
        .CLK_FREQ (CF),
        .LINES    (NL),
        .ENTRY_W  (16)
    ) dut (
        .clk             (clk),
        .rst_active_high (rst),
        .tempo           (tempo),
        .play_enable     (pe),
        .stop            (stop),
        .loop_enable     (loop_en),
        .wr_valid        (wv),
        .wr_ready        (wr_ready),
        .wr_addr         (wa),
        .wr_data         (wd),
        .current_entry   (current_entry),
        .line_count      (line_count),
        .line_strobe     (line_strobe),
        .playing         (playing),
        .phrase_done     (phrase_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model: phrase memory, playhead, and a plain integer tempo accumulator.
    int          ms, m_clr, m_line;
    longint      m_acc;
    logic [15:0] m_mem [NL];
    bit          m_strobe, m_done;

    task automatic m_reset();
        ms = S_CLEAR; m_clr = 0; m_line = 0; m_acc = 0;
        m_strobe = 0; m_done = 0;
        for (int i = 0; i < NL; i++) m_mem[i] = 16'h0;
    endtask

    task automatic m_step();
        int ns, nl;
        ns = ms; nl = m_line; m_strobe = 0; m_done = 0;
        if (ms == S_CLEAR) begin
            m_mem[m_clr] = 16'h0;
            m_clr++;
            if (m_clr == NL) ns = S_IDLE;
        end else begin
            if (stop && ms >= S_PLAY) begin
                ns = S_IDLE; nl = 0; m_acc = 0;
            end else begin
                case (ms)
                    S_IDLE: begin
                        m_acc = 0; nl = 0;
                        if (pe) ns = S_PLAY;
                    end
                    S_PLAY: begin
                        m_acc += tempo;
                        if (m_acc >= M) begin
                            m_acc -= M;
                            if (m_line == NL - 1 && !loop_en) begin
                                ns = S_DONE; m_done = 1;
                            end else begin
                                nl = (m_line + 1) % NL; m_strobe = 1;
                            end
                        end
                        if (ns == S_PLAY && !pe) ns = S_PAUSE;
                    end
                    S_PAUSE: if (pe) ns = S_PLAY;
                    S_DONE: if (!pe) begin ns = S_IDLE; nl = 0; end
                    default: ;
                endcase
            end
            if (wv) m_mem[wa] = wd;
        end
        ms = ns; m_line = nl;
    endtask

    task automatic check_outputs();
        chk("wr_ready",    wr_ready,      32'(ms != S_CLEAR));
        chk("playing",     playing,       32'(ms == S_PLAY));
        chk("line_count",  line_count,    32'(m_line));
        chk("entry",       current_entry, m_mem[m_line]);
        chk("line_strobe", line_strobe,   32'(m_strobe));
        chk("phrase_done", phrase_done,   32'(m_done));
    endtask

    // One clock: model and DUT advance on the same edge, outputs checked just after.
    task automatic tick();
        @(posedge clk);
        if (rst) m_reset(); else m_step();
        #1 check_outputs();
        @(negedge clk);
    endtask

    task automatic wait_strobe(input int limit, output int n);
        n = 0;
        do begin
            n++;
            tick();
        end while (!line_strobe && n < limit);
        if (!line_strobe) chk("strobe_timeout", 0, 1);
    endtask

    task automatic count_clear();
        int n;
        n = 0;
        while (!wr_ready && n < 100) begin
            n++;
            tick();
        end
        chk("clear_cycles", n, 16);
    endtask

    initial begin
        int n, cnt, prev;
        tempo = 9'd0; pe = 0; stop = 0; loop_en = 0; wv = 0; wa = 4'd0; wd = 16'h0;
        rst = 1'b1;
        m_reset();
        tick(); tick();
        chk("rst_line",  line_count, 0);
        chk("rst_entry", current_entry, 0);
        rst = 1'b0;
        count_clear();

        // Cleared phrase reads back as zero on every line.
        tempo = 9'd511; loop_en = 1; pe = 1;
        for (int k = 0; k < NL; k++) begin
            wait_strobe(20, n);
            chk("clr_line_zero", current_entry, 0);
        end
        stop = 1; pe = 0; tick(); stop = 0;

        for (int i = 0; i < NL; i++) begin
            wv = 1; wa = 4'(i); wd = 16'h1000 + 16'(i);
            tick();
        end
        wv = 0;

        // Looping playback at 120 lines/min: one step every 30 cycles.
        tempo = 9'd120; loop_en = 1; pe = 1;
        tick();
        cnt = 0; prev = -1;
        for (int t = 1; t <= 510; t++) begin
            tick();
            if (line_strobe) begin
                cnt++;
                if (prev < 0) chk("first_step", t, 30);
                else          chk("step_period", t - prev, 30);
                chk("seq_entry", current_entry, 16'h1000 + 16'(cnt % NL));
                prev = t;
            end
        end
        chk("strobe_count", cnt, 17);
        chk("wrap_line", line_count, 1);
        stop = 1; tick(); stop = 0;
        chk("stop_line", line_count, 0);

        // One-shot: parks on line 15 with a single phrase_done pulse.
        loop_en = 0;
        tick();
        n = 0;
        while (!phrase_done && n < 1000) begin
            n++;
            tick();
        end
        chk("done_latency", n, 480);
        chk("done_playing", playing, 0);
        chk("done_line", line_count, 15);
        tick();
        chk("done_pulse", phrase_done, 0);
        chk("done_hold", line_count, 15);
        pe = 0; tick();
        chk("done_idle_line", line_count, 0);

        // Pause 10 cycles into a line, hold, resume: 1 resume edge + 20 playing cycles.
        pe = 1; tick();
        wait_strobe(100, n);
        chk("pause_first", n, 30);
        repeat (9) tick();
        pe = 0; tick();
        repeat (100) tick();
        chk("pause_line", line_count, 1);
        chk("pause_playing", playing, 0);
        pe = 1;
        wait_strobe(100, n);
        chk("resume_gap", n, 21);

        // Live edits: current line, then next line on the step edge.
        wv = 1; wa = line_count; wd = 16'hBEEF; tick(); wv = 0;
        chk("edit_cur", current_entry, 16'hBEEF);
        repeat (28) tick();
        wv = 1; wa = line_count + 4'd1; wd = 16'hCAFE; tick(); wv = 0;
        chk("fwd_strobe", line_strobe, 1);
        chk("fwd_cur", current_entry, 16'hCAFE);

        tempo = 9'd0; cnt = 0; prev = int'(line_count);
        for (int t = 0; t < 1000; t++) begin
            tick();
            if (line_strobe) cnt++;
        end
        chk("tempo0_steps", cnt, 0);
        chk("tempo0_line", line_count, 32'(prev));

        // Stop landing on the same edge as a step wins.
        tempo = 9'd120;
        wait_strobe(100, n);
        repeat (29) tick();
        stop = 1; pe = 0; tick(); stop = 0;
        chk("stopstep_line", line_count, 0);
        chk("stopstep_strobe", line_strobe, 0);
        chk("stopstep_playing", playing, 0);

        // Asynchronous reset in the middle of line 7.
        tempo = 9'd511; loop_en = 1; pe = 1;
        n = 0;
        while (line_count != 4'd7 && n < 500) begin
            n++;
            tick();
        end
        chk("reach_line7", line_count, 7);
        repeat (3) tick();
        rst = 1'b1;
        m_reset();
        #1;
        chk("arst_line",    line_count, 0);
        chk("arst_entry",   current_entry, 0);
        chk("arst_ready",   wr_ready, 0);
        chk("arst_playing", playing, 0);
        chk("arst_strobe",  line_strobe, 0);
        @(negedge clk);
        tick();
        rst = 1'b0;
        pe = 0;
        count_clear();

        // Random phase against the model.
        for (int t = 0; t < 4000; t++) begin
            if ($urandom_range(0, 79) == 0) pe = ~pe;
            if ($urandom_range(0, 299) == 0) loop_en = ~loop_en;
            if ($urandom_range(0, 99) == 0)
                tempo = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom_range(200, 511));
            stop = ($urandom_range(0, 199) == 0);
            wv   = ($urandom_range(0, 3) == 0);
            wa   = 4'($urandom_range(0, NL - 1));
            wd   = 16'($urandom);
            tick();
        end
        stop = 0; wv = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
